// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared CPU types and constants (fetch/decode boundary)
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam logic [15:0] NOP_INSTR   = 16'h0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc2;
  } ifid_t;

  function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opcode);
    return instr[15:12] == opcode;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory request/response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;

  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_rdy_i;
  logic [15:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdy_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdy_i,
    output imem_data_i
  );

endinterface

`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
// ============================================================================
// ifid_pipe_reg : async-reset pipeline register with load/hold/flush
// Rev 1.0
// ============================================================================
`default_nettype none

module ifid_pipe_reg
  import cpu_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  i_load,
  input  wire logic  i_flush,
  input  wire ifid_t i_d,
  output ifid_t      o_q
);

  localparam ifid_t c_bubble = '{valid: 1'b0, instr: NOP_INSTR, pc2: 16'h0000};

  // Flush wins over load so a redirect always leaves a bubble behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= c_bubble;
    end else if (i_flush) begin
      o_q <= c_bubble;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC, imem request port, hold buffer and IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE,
  parameter logic [15:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall_i,
  input  wire logic        redirect_i,
  input  wire logic [15:0] redirect_pc_i,
  fetch_stage_if.master    imem,
  output logic             ifid_valid_o,
  output logic [15:0]      ifid_instr_o,
  output logic [15:0]      ifid_pc2_o,
  output logic             halt_fetched_o
);

  fetch_state_t r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_disc_addr;
  logic         r_hb_valid;
  logic [15:0]  r_hb_instr;
  logic         r_halt;

  logic         w_req;
  logic         w_fire;
  logic         w_accept;
  logic         w_drain;
  logic         w_load;
  logic         w_flush;
  logic [15:0]  w_new_instr;
  logic         w_new_halt;
  ifid_t        w_ifid_d;
  ifid_t        w_ifid_q;

  // A full hold buffer means the instruction at r_pc is already in hand.
  assign w_req       = !rst && (r_state != HALTED) && !r_hb_valid;
  assign w_fire      = w_req && imem.imem_rdy_i;
  assign w_accept    = (r_state == FETCH) && w_fire && !stall_i && !redirect_i;
  assign w_drain     = (r_state == FETCH) && r_hb_valid && !stall_i && !redirect_i;
  assign w_new_instr = r_hb_valid ? r_hb_instr : imem.imem_data_i;
  assign w_new_halt  = is_halt(w_new_instr, HALT_OPCODE);

  // The pc does not advance until the buffered word drains, so pc+2 covers both sources.
  assign w_ifid_d = '{valid: 1'b1, instr: w_new_instr, pc2: r_pc + 16'd2};
  assign w_load   = w_accept || w_drain;
  assign w_flush  = redirect_i ||
                    (!stall_i && (r_state == FETCH) && !r_hb_valid && !w_fire) ||
                    (!stall_i && (r_state == HALTED));

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = (r_state == DISCARD) ? r_disc_addr : r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_disc_addr <= 16'h0000;
      r_hb_valid  <= 1'b0;
      r_hb_instr  <= NOP_INSTR;
      r_halt      <= 1'b0;
    end else if (redirect_i) begin
      r_pc       <= redirect_pc_i;
      r_hb_valid <= 1'b0;
      r_halt     <= 1'b0;
      if (w_req && !imem.imem_rdy_i) begin
        r_state <= DISCARD;
        if (r_state == FETCH) begin
          r_disc_addr <= r_pc;
        end
      end else begin
        r_state <= FETCH;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (stall_i) begin
            if (w_fire) begin
              r_hb_valid <= 1'b1;
              r_hb_instr <= imem.imem_data_i;
            end
          end else if (w_load) begin
            r_pc       <= r_pc + 16'd2;
            r_hb_valid <= 1'b0;
            if (w_new_halt) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
            end
          end
        end
        DISCARD: begin
          if (imem.imem_rdy_i) begin
            r_state <= FETCH;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  ifid_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign ifid_valid_o   = w_ifid_q.valid;
  assign ifid_instr_o   = w_ifid_q.instr;
  assign ifid_pc2_o     = w_ifid_q.pc2;
  assign halt_fetched_o = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : randomized program-stream scoreboard for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam logic [15:0] NOP    = 16'h0000;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [3:0]  HLT    = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0000;
  logic        ifid_valid_o;
  logic [15:0] ifid_instr_o;
  logic [15:0] ifid_pc2_o;
  logic        halt_fetched_o;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem           (imem),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_instr_o   (ifid_instr_o),
    .ifid_pc2_o     (ifid_pc2_o),
    .halt_fetched_o (halt_fetched_o)
  );

  always #5 clk = ~clk;

  // Program image, mirrored every 512 bytes of address space.
  logic [15:0] mem [256];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] push_pc;
  bit          push_halted;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // What the DUT saw at the upcoming edge, plus the protocol view before it.
  bit          e_req, e_rdy, e_stall, e_redir, e_disc;
  logic [15:0] e_addr, e_data, e_tgt, e_last_tgt;
  bit          disc;
  logic [15:0] last_tgt;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected program-order stream: successive words from the fetch address until a HLT.
  task automatic top_up();
    logic [15:0] w;
    while (exp_q.size() < 4 && !push_halted) begin
      w = mem[push_pc[8:1]];
      exp_q.push_back('{instr: w, pc2: 16'(push_pc + 16'd2)});
      if (w[15:12] == HLT) push_halted = 1'b1;
      push_pc = 16'(push_pc + 16'd2);
    end
  endtask

  task automatic restart(input logic [15:0] t);
    exp_q.delete();
    push_pc     = t;
    push_halted = 1'b0;
    top_up();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    redirect_i = 1'b0;
    imem.imem_rdy_i = 1'b0;
    #1 chk(!ifid_valid_o && ifid_instr_o == NOP && ifid_pc2_o == 16'h0 && !halt_fetched_o && !imem.imem_req_o,
           "reset_state", {ifid_valid_o, halt_fetched_o, imem.imem_req_o, 13'h0, ifid_instr_o},
           {3'b000, 13'h0, NOP});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk(imem.imem_req_o && imem.imem_addr_o == RST_PC, "reset_release",
           {15'h0, imem.imem_req_o, imem.imem_addr_o}, {15'h0, 1'b1, RST_PC});
    disc     = 1'b0;
    last_tgt = RST_PC;
    restart(RST_PC);
    mon_en = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (e_redir) begin
          chk(!ifid_valid_o && !halt_fetched_o, "redirect_flush",
              {30'h0, ifid_valid_o, halt_fetched_o}, 32'h0);
        end else if (!e_stall && ifid_valid_o) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_instr", {ifid_instr_o, ifid_pc2_o}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk(ifid_instr_o == e.instr && ifid_pc2_o == e.pc2, "ifid_instr",
                {ifid_instr_o, ifid_pc2_o}, {e.instr, e.pc2});
            if (e.instr[15:12] == HLT)
              chk(halt_fetched_o && !imem.imem_req_o, "halt_fetched",
                  {30'h0, halt_fetched_o, imem.imem_req_o}, 32'h2);
            else
              chk(!halt_fetched_o, "no_halt", {31'h0, halt_fetched_o}, 32'h0);
          end
        end
        if (!ifid_valid_o)
          chk(ifid_instr_o == NOP, "bubble_nop", {16'h0, ifid_instr_o}, {16'h0, NOP});

        if (e_req && !e_rdy)
          chk(imem.imem_req_o && imem.imem_addr_o == e_addr, "addr_stable",
              {15'h0, imem.imem_req_o, imem.imem_addr_o}, {15'h0, 1'b1, e_addr});
        else if (e_redir)
          chk(imem.imem_req_o && imem.imem_addr_o == e_tgt, "redirect_target",
              {15'h0, imem.imem_req_o, imem.imem_addr_o}, {15'h0, 1'b1, e_tgt});
        else if (e_disc && e_rdy)
          chk(imem.imem_req_o && imem.imem_addr_o == e_last_tgt, "discard_done",
              {15'h0, imem.imem_req_o, imem.imem_addr_o}, {15'h0, 1'b1, e_last_tgt});
        else if (e_stall && e_req && e_rdy)
          chk(!imem.imem_req_o, "hold_req_low", {31'h0, imem.imem_req_o}, 32'h0);
        else if (!e_stall && e_req && e_rdy && e_data[15:12] != HLT)
          chk(imem.imem_req_o && imem.imem_addr_o == 16'(e_addr + 16'd2), "next_req",
              {15'h0, imem.imem_req_o, imem.imem_addr_o}, {15'h0, 1'b1, 16'(e_addr + 16'd2)});
      end
    end
  end

  // Stimulus and imem responder
  initial begin
    bit rnd, st, rd, rdy;
    logic [15:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
    mem[0]   = 16'h1111;
    mem[1]   = 16'h2222;
    mem[5]   = 16'hF000;
    mem[60]  = 16'hF123;
    mem[200] = 16'hFABC;
    imem.imem_rdy_i  = 1'b0;
    imem.imem_data_i = 16'h0000;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || cyc == 1000 || cyc == 2000) do_reset();
      rnd = (cyc >= 41);
      st  = (cyc >= 1995 && cyc < 2000) ? 1'b1 : (rnd && ($urandom_range(3, 0) == 0));
      rd  = (cyc == 40) || (cyc == 500) || (rnd && ($urandom_range(15, 0) == 0));
      tgt = (cyc == 40) ? 16'h0020 :
            (cyc == 500 || $urandom_range(7, 0) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
      rdy = imem.imem_req_o && (!rnd || ($urandom_range(2, 0) == 0));

      stall_i          = st;
      redirect_i       = rd;
      redirect_pc_i    = tgt;
      imem.imem_rdy_i  = rdy;
      imem.imem_data_i = mem[imem.imem_addr_o[8:1]];

      e_req   = imem.imem_req_o;
      e_addr  = imem.imem_addr_o;
      e_rdy   = rdy;
      e_data  = imem.imem_data_i;
      e_stall = st;
      e_redir = rd;
      e_tgt   = tgt;
      e_disc  = disc;
      e_last_tgt = last_tgt;

      if (rd) begin
        last_tgt = tgt;
        restart(tgt);
      end
      top_up();
      // An unanswered request at a redirect becomes stale until its response arrives.
      disc = rd ? (e_req && !rdy) : (disc && !rdy);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
